// File: rtl/bram_arbiter_pkg.sv
// Shared constants and FSM state type for the block RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bram_arbiter_pkg;

  localparam int RAM_DEPTH   = 256;
  localparam int RAM_ADDR_W  = 8;
  localparam int RAM_DATA_W  = 16;
  localparam int PRIM_ADDR_W = 11;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/bram_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer, with wrap-around.
// Latency: grant is combinational from req and the pointer; the pointer moves on the next edge.
// Backpressure: a requester not granted simply keeps req high; the pointer holds when nothing is granted.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic             found;
  int               cand;

  // Scan upward from the pointer and take the first active request.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found        = 1'b1;
        grant[cand]  = 1'b1;
        grant_idx    = IDX_W'(cand);
      end
    end
    ptr_d = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
  end

  // Pointer moves past the winner only when a grant actually happens.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (advance && found) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one 256x16 block RAM between NUM_REQ requesters; zero-fills the RAM after reset or on clear_req.
// Latency: grants are combinational; read data returns exactly one cycle after the read grant.
// Backpressure: ready is held low during the clear and for requesters that lose arbitration.
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = RAM_ADDR_W,
  parameter int DATA_W  = RAM_DATA_W,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear_req,
  output logic                      busy,
  input  logic [NUM_REQ-1:0]        rd_valid,
  output logic [NUM_REQ-1:0]        rd_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] rd_addr,
  output logic [NUM_REQ-1:0]        rd_resp_valid,
  output logic [DATA_W-1:0]         rd_resp_data,
  input  logic [NUM_REQ-1:0]        wr_valid,
  output logic [NUM_REQ-1:0]        wr_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] wr_addr,
  input  logic [NUM_REQ*DATA_W-1:0] wr_data,
  output logic [PRIM_ADDR_W-1:0]    ram_raddr,
  output logic                      ram_re,
  output logic [PRIM_ADDR_W-1:0]    ram_waddr,
  output logic                      ram_we,
  output logic [DATA_W-1:0]         ram_wdata,
  output logic [DATA_W-1:0]         ram_mask,
  input  logic [DATA_W-1:0]         ram_rdata
);

  state_e             state_q;
  logic [ADDR_W-1:0]  clr_q;
  logic               run_en;
  logic               clr_en;
  logic [NUM_REQ-1:0] rd_req;
  logic [NUM_REQ-1:0] wr_req;
  logic [NUM_REQ-1:0] rd_grant;
  logic [NUM_REQ-1:0] wr_grant;
  logic [IDX_W-1:0]   rd_idx;
  logic [IDX_W-1:0]   wr_idx;
  logic               rsp_vld_q;
  logic [IDX_W-1:0]   rsp_idx_q;
  logic [DATA_W-1:0]  hold_q;

  // Reset masks every grant and RAM strobe combinationally so nothing leaks out while it is held.
  assign run_en = (state_q == ST_RUN) && !reset;
  assign clr_en = (state_q == ST_CLEAR) && !reset;
  assign busy   = (state_q == ST_CLEAR) || reset;
  assign rd_req = rd_valid & {NUM_REQ{run_en}};
  assign wr_req = wr_valid & {NUM_REQ{run_en}};

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rd_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (rd_req),
    .advance   (run_en),
    .grant     (rd_grant),
    .grant_idx (rd_idx)
  );

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_wr_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (wr_req),
    .advance   (run_en),
    .grant     (wr_grant),
    .grant_idx (wr_idx)
  );

  assign rd_ready = rd_grant;
  assign wr_ready = wr_grant;
  assign ram_re   = |rd_grant;
  assign ram_mask = '0;

  // Read port: address of the granted requester, zero-extended to the primitive width.
  always_comb begin
    ram_raddr               = '0;
    ram_raddr[ADDR_W-1:0]   = rd_addr[rd_idx*ADDR_W +: ADDR_W];
  end

  // Write port: the clear sweep owns it in CLEAR, the write winner owns it in RUN.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (clr_en) begin
      ram_we                = 1'b1;
      ram_waddr[ADDR_W-1:0] = clr_q;
    end else if (|wr_grant) begin
      ram_we                = 1'b1;
      ram_waddr[ADDR_W-1:0] = wr_addr[wr_idx*ADDR_W +: ADDR_W];
      ram_wdata             = wr_data[wr_idx*DATA_W +: DATA_W];
    end
  end

  // CLEAR sweeps every address once, then RUN; clear_req is only honoured from RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      clr_q   <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_q <= clr_q + ADDR_W'(1);
          if (clr_q == ADDR_W'(RAM_DEPTH - 1)) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (clear_req) begin
            state_q <= ST_CLEAR;
            clr_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_CLEAR;
          clr_q   <= '0;
        end
      endcase
    end
  end

  // Remember who was granted so the RAM output can be steered back one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_vld_q <= 1'b0;
      rsp_idx_q <= '0;
    end else begin
      rsp_vld_q <= |rd_grant;
      if (|rd_grant) rsp_idx_q <= rd_idx;
    end
  end

  // Keep the last returned word so rd_resp_data is stable between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
    end else if (rsp_vld_q) begin
      hold_q <= ram_rdata;
    end
  end

  assign rd_resp_data = rsp_vld_q ? ram_rdata : hold_q;

  // Response strobe is one-hot on the stored index; dropped while reset is high.
  always_comb begin
    rd_resp_valid = '0;
    if (rsp_vld_q && !reset) rd_resp_valid[rsp_idx_q] = 1'b1;
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter with a behavioural READ_MODE 0 RAM model.
// Latency: checks one-cycle read return and 256-cycle clears.
// Backpressure: checks that grants are withheld during clears and follow round-robin order.
module tb_bram_arbiter;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            clear_req;
  logic            busy;
  logic [N-1:0]    rd_valid;
  logic [N-1:0]    rd_ready;
  logic [N*AW-1:0] rd_addr;
  logic [N-1:0]    rd_resp_valid;
  logic [DW-1:0]   rd_resp_data;
  logic [N-1:0]    wr_valid;
  logic [N-1:0]    wr_ready;
  logic [N*AW-1:0] wr_addr;
  logic [N*DW-1:0] wr_data;
  logic [10:0]     ram_raddr;
  logic            ram_re;
  logic [10:0]     ram_waddr;
  logic            ram_we;
  logic [DW-1:0]   ram_wdata;
  logic [DW-1:0]   ram_mask;
  logic [DW-1:0]   ram_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          idx;
    logic [15:0] dat;
  } exp_t;
  exp_t exp_q[$];

  bram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .clear_req     (clear_req),
    .busy          (busy),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_addr       (rd_addr),
    .rd_resp_valid (rd_resp_valid),
    .rd_resp_data  (rd_resp_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .ram_raddr     (ram_raddr),
    .ram_re        (ram_re),
    .ram_waddr     (ram_waddr),
    .ram_we        (ram_we),
    .ram_wdata     (ram_wdata),
    .ram_mask      (ram_mask),
    .ram_rdata     (ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: registered read returns old contents on a same-address write.
  logic [15:0] mem [0:2047];
  initial for (int i = 0; i < 2048; i++) mem[i] = 16'hA5A5;
  always @(posedge clk) begin
    if (ram_re) ram_rdata <= mem[ram_raddr];
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every response strobe pops one expected entry.
  always @(negedge clk) begin
    if (rd_resp_valid !== 3'b000) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(rd_resp_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_onehot", 32'(rd_resp_valid), 32'(1 << e.idx));
        check("rsp_data", 32'(rd_resp_data), 32'(e.dat));
      end
    end
  end

  task automatic set_rd(input int i, input logic [7:0] a);
    rd_addr[i*AW +: AW] = a;
  endtask

  task automatic set_wr(input int i, input logic [7:0] a, input logic [15:0] d);
    wr_addr[i*AW +: AW] = a;
    wr_data[i*DW +: DW] = d;
  endtask

  task automatic push(input int idx, input logic [15:0] d);
    exp_t e;
    e.idx = idx;
    e.dat = d;
    exp_q.push_back(e);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 of the first clear cycle; ends at posedge+1 after the first RUN cycle.
  task automatic run_clear(input string tag, input int hold, input int reclear);
    int  nb;
    bit  done;
    nb   = 0;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      rd_valid  = (c < hold) ? 3'b111 : 3'b000;
      wr_valid  = (c < hold) ? 3'b111 : 3'b000;
      clear_req = (c == reclear);
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        check({tag, "_run_rdy"}, 32'({rd_ready, wr_ready}), 32'd0);
        check({tag, "_run_we"}, 32'({ram_we, ram_re}), 32'd0);
      end else begin
        if (ram_we !== 1'b1 || ram_waddr !== 11'(nb) || ram_wdata !== 16'h0000)
          check({tag, "_clr_wr"}, {4'h0, ram_we, ram_waddr, ram_wdata}, {4'h0, 1'b1, 11'(nb), 16'h0000});
        else
          check({tag, "_clr_wr"}, 32'(ram_waddr), 32'(nb));
        if ({rd_ready, wr_ready, ram_re} !== '0)
          check({tag, "_clr_nogrant"}, 32'({rd_ready, wr_ready, ram_re}), 32'd0);
        nb++;
      end
      step();
    end
    clear_req = 1'b0;
    check({tag, "_busy_cycles"}, 32'(nb), 32'd256);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; clear_req = 1'b0;
    rd_valid = 3'b111; wr_valid = 3'b111;
    rd_addr = '0; wr_addr = '0; wr_data = '0;

    // Reset state.
    step();
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ready", 32'({rd_ready, wr_ready}), 32'd0);
    check("rst_resp", 32'(rd_resp_valid), 32'd0);
    check("rst_re_we", 32'({ram_re, ram_we}), 32'd0);
    check("mask", 32'(ram_mask), 32'd0);
    step();
    reset = 1'b0; rd_valid = '0; wr_valid = '0;
    run_clear("clr0", 0, -1);

    // Write by req1, then read-back by req2.
    wr_valid = 3'b010; set_wr(1, 8'h10, 16'hBEEF);
    @(negedge clk);
    check("wr1_ready", 32'(wr_ready), 32'b010);
    check("wr1_port", {ram_we, ram_waddr, 4'h0, ram_wdata}, {1'b1, 11'h010, 4'h0, 16'hBEEF});
    step();
    wr_valid = 3'b000; rd_valid = 3'b100; set_rd(2, 8'h10); push(2, 16'hBEEF);
    @(negedge clk);
    check("rd2_ready", 32'(rd_ready), 32'b100);
    check("rd2_port", 32'({ram_re, ram_raddr}), 32'({1'b1, 11'h010}));
    step();
    rd_valid = 3'b000;

    // Three simultaneous writers; write pointer sits at 2, so order is 2,0,1.
    for (int i = 0; i < 3; i++) set_wr(i, 8'(8'h01 + i), 16'(16'h1111 * (i + 1)));
    wr_valid = 3'b111;
    @(negedge clk); check("wrr_g0", 32'(wr_ready), 32'b100);
    step(); wr_valid = 3'b011;
    @(negedge clk); check("wrr_g1", 32'(wr_ready), 32'b001);
    step(); wr_valid = 3'b010;
    @(negedge clk); check("wrr_g2", 32'(wr_ready), 32'b010);
    step(); wr_valid = 3'b000;

    // Three readers held for six cycles: grants rotate 0,1,2,0,1,2.
    for (int i = 0; i < 3; i++) set_rd(i, 8'(8'h01 + i));
    rd_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      push(c % 3, 16'(16'h1111 * ((c % 3) + 1)));
      @(negedge clk);
      check("rrr_grant", 32'(rd_ready), 32'(1 << (c % 3)));
      step();
    end
    rd_valid = 3'b000;
    step();

    // Same-address write and read in one cycle: read sees old data.
    wr_valid = 3'b001; set_wr(0, 8'h20, 16'h1234);
    rd_valid = 3'b010; set_rd(1, 8'h20); push(1, 16'h0000);
    @(negedge clk);
    check("rw_same_grant", 32'({rd_ready, wr_ready}), 32'({3'b010, 3'b001}));
    step();
    wr_valid = 3'b000; push(1, 16'h1234);
    @(negedge clk);
    check("rw_repeat_grant", 32'(rd_ready), 32'b010);
    step();
    rd_valid = 3'b000;
    step();

    // Write 0xFFFF to 0xFF, then clear_req in a cycle with a read of 0xFF.
    wr_valid = 3'b100; set_wr(2, 8'hFF, 16'hFFFF);
    @(negedge clk);
    check("wff_grant", 32'(wr_ready), 32'b100);
    step();
    wr_valid = 3'b000; clear_req = 1'b1;
    rd_valid = 3'b001; set_rd(0, 8'hFF); push(0, 16'hFFFF);
    @(negedge clk);
    check("clrreq_rd_grant", 32'(rd_ready), 32'b001);
    check("clrreq_busy", 32'(busy), 32'd0);
    step();
    run_clear("clr1", 200, 100);
    rd_valid = 3'b010; set_rd(1, 8'hFF); push(1, 16'h0000);
    @(negedge clk);
    check("post_clr_grant", 32'(rd_ready), 32'b010);
    step();
    rd_valid = 3'b000;
    step();

    // Reset the cycle after a read grant: response dropped, clear restarts at 0.
    rd_valid = 3'b010; set_rd(1, 8'h02);
    wr_valid = 3'b001; set_wr(0, 8'h30, 16'h5555);
    @(negedge clk);
    check("pre_rst_grant", 32'({rd_ready, wr_ready}), 32'({3'b010, 3'b001}));
    step();
    rd_valid = 3'b000; wr_valid = 3'b000; reset = 1'b1;
    @(negedge clk);
    check("rst_drop_resp", 32'(rd_resp_valid), 32'd0);
    check("rst_busy2", 32'({busy, ram_we}), 32'b10);
    step();
    reset = 1'b0;
    run_clear("clr2", 0, -1);

    // Pointers are back at requester 0 after reset.
    rd_valid = 3'b111; wr_valid = 3'b111; push(0, 16'h0000);
    @(negedge clk);
    check("ptr_rst_rd", 32'(rd_ready), 32'b001);
    check("ptr_rst_wr", 32'(wr_ready), 32'b001);
    step();
    rd_valid = 3'b000; wr_valid = 3'b000;
    repeat (3) step();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
Shares one 256x16 iCE40 block RAM (SB_RAM40_4K, READ_MODE 0) between NUM_REQ requesters.
- Arbitrates the read port and the write port independently with round-robin priority, so one read and one write can be granted per cycle.
- Returns read data with fixed latency to the granted requester.
- After reset, or on request, it zero-fills the RAM before accepting traffic.
- Sits between the pulse-processing blocks and the shared RAM primitive.

Parameters:
NUM_REQ, 3, number of requesters (2..4)
ADDR_W, 8, RAM word address width (256 x 16 configuration)
DATA_W, 16, RAM data width (fixed by the primitive)

Ports:
clk  input  1  system clock; also drives the RAM RCLK and WCLK
reset  input  1  synchronous, active-high reset
clear_req  input  1  pulse: start a zero-fill of the whole RAM
busy  output  1  high while clearing
rd_valid  input  NUM_REQ  per-requester read request
rd_ready  output  NUM_REQ  per-requester read grant; one-hot or zero
rd_addr  input  NUM_REQ*ADDR_W  flattened read addresses; requester i at [i*ADDR_W +: ADDR_W]
rd_resp_valid  output  NUM_REQ  one-hot; read data valid for requester i
rd_resp_data  output  DATA_W  read data, shared by all requesters
wr_valid  input  NUM_REQ  per-requester write request
wr_ready  output  NUM_REQ  per-requester write grant; one-hot or zero
wr_addr  input  NUM_REQ*ADDR_W  flattened write addresses
wr_data  input  NUM_REQ*DATA_W  flattened write data
ram_raddr  output  11  RAM read address; zero-extended
ram_re  output  1  RAM read enable
ram_waddr  output  11  RAM write address; zero-extended
ram_we  output  1  RAM write enable
ram_wdata  output  16  RAM write data
ram_mask  output  16  RAM write mask; constant 0, all bits written
ram_rdata  input  16  RAM read data

Behaviour:
- Reset:
  - FSM enters CLEAR with clr_addr=0.
  - All ready and resp_valid outputs are 0.
  - busy=1.
  - Both round-robin pointers start at requester 0.
  - ram_re=0, ram_we=0.
- FSM states CLEAR and RUN.
- CLEAR:
  - Each cycle: ram_we=1, ram_waddr=clr_addr, ram_wdata=0; clr_addr increments.
  - After address 255 has been written, go to RUN.
  - A full clear takes exactly 256 cycles.
  - All rd_ready and wr_ready are 0.
  - Reads are not issued.
- RUN:
  - busy=0.
  - clear_req=1 moves to CLEAR on the next cycle with clr_addr=0. Grants in that cycle still complete.
  - clear_req during CLEAR is ignored; the clear does not restart.
- Handshake:
  - A transfer occurs when valid[i] && ready[i]. ready is combinational from valid and the pointer.
  - The requester must hold valid, addr and data stable until ready.
- Arbitration:
  - Search starts at the pointer and scans upward with wrap-around; the first requester with valid set is granted.
  - After a grant to requester i, the pointer becomes (i+1) mod NUM_REQ.
  - If there is no grant, the pointer is unchanged.
  - Read and write arbiters are independent.
- Read path:
  - On a read grant in cycle T: ram_re=1 and ram_raddr=rd_addr[i] in cycle T.
  - In cycle T+1: rd_resp_valid[i]=1 and rd_resp_data=ram_rdata.
  - Latency is 1. Throughput is one read per cycle, with back-to-back reads from different requesters allowed.
  - The requester index is held in a 1-stage register.
  - reset clears rd_resp_valid, so an in-flight response is dropped.
- Write path:
  - On a write grant in cycle T: ram_we=1, with ram_waddr and ram_wdata from the granted requester, in cycle T.
- Same-address read and write granted in the same cycle:
  - The read returns the old contents; no forwarding.
  - A read granted at T+1 returns the new data.
- Read during the transition to CLEAR: the read granted in the last RUN cycle still gets its response at T+1.
- rd_resp_data holds its last value when rd_resp_valid=0. Requesters must qualify it with rd_resp_valid.

Decomposition:
- Package bram_arbiter_pkg: RAM_DEPTH=256, RAM_ADDR_W=8, RAM_DATA_W=16, PRIM_ADDR_W=11, and an FSM state enum {ST_CLEAR, ST_RUN}.
- Sub-module rr_arbiter (parameter N), instantiated twice, once for read and once for write.
  - Inputs: clk, reset, req[N], advance.
  - Outputs: grant[N] one-hot, grant_idx.
  - Owns the pointer.

Test Plan:
- Reset for 1 cycle, then idle: busy=1 for exactly 256 cycles, ram_we=1 with ram_waddr 0..255 and ram_wdata=0; then busy=0 and all ready outputs 0.
- Requester 1 writes addr 0x10, data 0xBEEF; requester 2 reads 0x10 in the next cycle: rd_resp_valid=3'b100 and rd_resp_data=0xBEEF one cycle after the read grant.
- All three requesters hold rd_valid for 6 cycles: grants cycle 0,1,2,0,1,2, and responses are one-hot in the same order, each delayed by 1.
- Write 0x1234 to 0x20 and a read of 0x20 granted in the same cycle: the read returns the old value 0x0000; a repeat read returns 0x1234.
- clear_req after writing 0xFFFF to 0xFF: 256 busy cycles with no grants, then a read of 0xFF returns 0x0000. A second clear_req mid-clear does not extend busy beyond 256 cycles.
- Reset asserted the cycle after a read grant: rd_resp_valid stays 0, and the clear sequence restarts at address 0.
